// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the IF/MEM memory-port arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package mem_port_arbiter_pkg;

    // Arbiter FSM states: idle, data access in flight, instruction fetch in flight
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        FETCH = 2'd2
    } arb_state_t;

    // Consecutive data grants allowed while a fetch is waiting
    localparam int DEFAULT_MAX_DATA_STREAK = 4;

    // Width of the data-streak counter (limit is at most 15)
    localparam int STREAK_W = 4;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between IF fetches and MEM-stage loads/stores; data has priority with a streak limit.
// Latency: request registered one cycle after it is seen in IDLE; result/done registered one cycle after ext_ack.
// Backpressure: one request outstanding; data_ready_mem low holds the whole pipeline until the data access completes.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX_DATA_STREAK = DEFAULT_MAX_DATA_STREAK
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        fetch_req,
    input  logic [31:0] fetch_addr,
    input  logic        if_flush,
    output logic        fetch_valid,
    output logic [31:0] fetch_rdata,
    input  logic        memread_mem,
    input  logic        memwrite_mem,
    input  logic [31:0] alu_result_mem,
    input  logic [31:0] write_data_memory_mem,
    output logic [31:0] data_from_memory_mem,
    output logic        data_ready_mem,
    output logic        ext_req,
    output logic        ext_we,
    output logic [31:0] ext_addr,
    output logic [31:0] ext_wdata,
    input  logic        ext_ack,
    input  logic [31:0] ext_rdata
);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

    arb_state_t          state;
    logic [STREAK_W-1:0] streak;
    logic                kill;
    logic                data_done;

    logic mem_access;
    logic data_pend;
    logic fetch_go;
    logic fetch_turn;
    logic data_wins;

    assign mem_access = memread_mem | memwrite_mem;
    assign data_pend  = mem_access & ~data_done;
    assign fetch_go   = fetch_req & ~if_flush;
    assign fetch_turn = fetch_go & (streak == STREAK_MAX);
    // In the data_done cycle the finished access is still on the inputs while
    // the pipeline advances; it keeps data's priority slot (no re-issue, and
    // no fetch slipping ahead of the streak rule), so the cycle is spent idle.
    assign data_wins  = mem_access & ~fetch_turn;

    // The pipeline may advance when there is no MEM access or the access just finished
    assign data_ready_mem = ~mem_access | data_done;

    // Arbiter FSM: grant, track completion, streak counting and fetch kill
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state                <= IDLE;
            streak               <= '0;
            kill                 <= 1'b0;
            data_done            <= 1'b0;
            ext_req              <= 1'b0;
            ext_we               <= 1'b0;
            ext_addr             <= '0;
            ext_wdata            <= '0;
            fetch_valid          <= 1'b0;
            fetch_rdata          <= '0;
            data_from_memory_mem <= '0;
        end else begin
            data_done   <= 1'b0;
            fetch_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (data_wins) begin
                        if (data_pend) begin
                            state     <= DATA;
                            ext_req   <= 1'b1;
                            ext_we    <= memwrite_mem;
                            ext_addr  <= alu_result_mem;
                            ext_wdata <= write_data_memory_mem;
                            if (fetch_req && (streak != STREAK_MAX)) begin
                                streak <= streak + 1'b1;
                            end
                        end
                    end else if (fetch_go) begin
                        state     <= FETCH;
                        ext_req   <= 1'b1;
                        ext_we    <= 1'b0;
                        ext_addr  <= fetch_addr;
                        ext_wdata <= '0;
                        streak    <= '0;
                    end
                    if (!fetch_req) begin
                        streak <= '0;
                    end
                end
                DATA: begin
                    if (ext_ack) begin
                        state     <= IDLE;
                        ext_req   <= 1'b0;
                        data_done <= 1'b1;
                        if (!ext_we) begin
                            data_from_memory_mem <= ext_rdata;
                        end
                    end
                end
                FETCH: begin
                    if (if_flush) begin
                        kill <= 1'b1;
                    end
                    if (ext_ack) begin
                        state   <= IDLE;
                        ext_req <= 1'b0;
                        kill    <= 1'b0;
                        if (!kill && !if_flush) begin
                            fetch_valid <= 1'b1;
                            fetch_rdata <= ext_rdata;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    ext_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: transaction-level model plus directed and random stimulus.
// Latency: checks every cycle at the falling edge; combinational data_ready_mem checked after inputs settle.
// Backpressure: stimulus holds MEM accesses until data_ready_mem and fetches until fetch_valid or if_flush.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int MAXS = DEFAULT_MAX_DATA_STREAK;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        fetch_req, if_flush, fetch_valid;
    logic [31:0] fetch_addr, fetch_rdata;
    logic        memread_mem, memwrite_mem, data_ready_mem;
    logic [31:0] alu_result_mem, write_data_memory_mem, data_from_memory_mem;
    logic        ext_req, ext_we, ext_ack;
    logic [31:0] ext_addr, ext_wdata, ext_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MAX_DATA_STREAK(MAXS)) dut (
        .clk(clk), .rstn(rstn),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .if_flush(if_flush),
        .fetch_valid(fetch_valid), .fetch_rdata(fetch_rdata),
        .memread_mem(memread_mem), .memwrite_mem(memwrite_mem),
        .alu_result_mem(alu_result_mem), .write_data_memory_mem(write_data_memory_mem),
        .data_from_memory_mem(data_from_memory_mem), .data_ready_mem(data_ready_mem),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_ack(ext_ack), .ext_rdata(ext_rdata)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    endtask

    // ---------------- transaction-level reference model ----------------
    bit          m_busy, m_isdata, m_we, m_killed, m_done, m_fv;
    logic [31:0] m_addr, m_wdata, m_frd, m_dout;
    int          m_streak;
    bit          grants[$];   // 0 = data grant, 1 = fetch grant
    bit          prev_rdy;

    task automatic model_reset();
        m_busy = 0; m_isdata = 0; m_we = 0; m_killed = 0; m_done = 0; m_fv = 0;
        m_addr = '0; m_wdata = '0; m_frd = '0; m_dout = '0; m_streak = 0;
        prev_rdy = 1;
    endtask

    task automatic model_step();
        bit acc, fgo, fturn, n_done, n_fv;
        acc = memread_mem | memwrite_mem;
        fgo = fetch_req & ~if_flush;
        n_done = 0;
        n_fv = 0;
        if (m_busy) begin
            if (!m_isdata && if_flush) m_killed = 1;
            if (ext_ack) begin
                if (m_isdata) begin
                    if (!m_we) m_dout = ext_rdata;
                    n_done = 1;
                end else if (!m_killed) begin
                    n_fv = 1;
                    m_frd = ext_rdata;
                end
                m_busy = 0;
                m_killed = 0;
            end
        end else begin
            fturn = fgo && (m_streak >= MAXS);
            if (acc && !fturn) begin
                if (!m_done) begin
                    m_busy = 1; m_isdata = 1; m_we = memwrite_mem;
                    m_addr = alu_result_mem; m_wdata = write_data_memory_mem;
                    grants.push_back(1'b0);
                    if (fetch_req && m_streak < MAXS) m_streak++;
                end
            end else if (fgo) begin
                m_busy = 1; m_isdata = 0; m_we = 0; m_addr = fetch_addr;
                grants.push_back(1'b1);
                m_streak = 0;
            end
            if (!fetch_req) m_streak = 0;
        end
        m_done = n_done;
        m_fv = n_fv;
    endtask

    // ---------------- memory responder ----------------
    int mem_phase = 0, mem_cnt = 0, mem_lat = 1;
    bit rand_lat = 0, force_ack = 0, force_rd_en = 0;
    logic [31:0] force_rd = '0;

    task automatic mem_respond();
        ext_ack = 1'b0;
        ext_rdata = $urandom;
        if (mem_phase == 2 && !ext_req) mem_phase = 0;
        if (mem_phase == 0 && ext_req) begin
            mem_phase = 1;
            mem_cnt = rand_lat ? int'($urandom_range(1, 4)) : mem_lat;
        end else if (mem_phase == 1) begin
            mem_cnt--;
            if (mem_cnt <= 0) begin
                ext_ack = 1'b1;
                if (force_rd_en) ext_rdata = force_rd;
                mem_phase = 2;
            end
        end
        if (force_ack) begin
            ext_ack = 1'b1;
            if (force_rd_en) ext_rdata = force_rd;
        end
    endtask

    // ---------------- per-cycle compare ----------------
    logic last_fv, last_rdy;

    task automatic check_regs();
        last_fv = fetch_valid;
        chk1("ext_req", ext_req, m_busy);
        if (m_busy) begin
            chk1("ext_we", ext_we, m_we);
            chk("ext_addr", ext_addr, m_addr);
            if (m_isdata) chk("ext_wdata", ext_wdata, m_wdata);
        end
        chk1("fetch_valid", fetch_valid, m_fv);
        if (m_fv) chk("fetch_rdata", fetch_rdata, m_frd);
        chk("data_from_memory_mem", data_from_memory_mem, m_dout);
    endtask

    // Inputs for the current cycle are already set by the caller
    task automatic commit();
        logic exp_rdy;
        mem_respond();
        #1;
        exp_rdy = ~(memread_mem | memwrite_mem) | m_done;
        last_rdy = data_ready_mem;
        chk1("data_ready_mem", data_ready_mem, exp_rdy);
        prev_rdy = exp_rdy;
        model_step();
        @(negedge clk);
        check_regs();
    endtask

    task automatic idle_inputs();
        memread_mem = 0; memwrite_mem = 0; fetch_req = 0; if_flush = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [4:0]  req_bits, rdy_bits;
        logic [9:0]  mg, dg;
        bit          dgr[$];
        bit          got, saw200, prev_dreq;
        logic        cap_we;
        logic [31:0] cap_addr, cap_wdata;
        int          fv_cnt;
        int unsigned r;

        idle_inputs();
        fetch_addr = '0; alu_result_mem = '0; write_data_memory_mem = '0;
        ext_ack = 0; ext_rdata = '0;
        model_reset();

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk1("rst_ext_req", ext_req, 1'b0);
        chk1("rst_ext_we", ext_we, 1'b0);
        chk("rst_ext_addr", ext_addr, 32'h0);
        chk("rst_ext_wdata", ext_wdata, 32'h0);
        chk1("rst_fetch_valid", fetch_valid, 1'b0);
        chk("rst_fetch_rdata", fetch_rdata, 32'h0);
        chk("rst_dout", data_from_memory_mem, 32'h0);
        chk1("rst_data_ready", data_ready_mem, 1'b1);
        @(negedge clk);
        rstn = 1;

        // Load alone, L=2
        force_rd_en = 1; force_rd = 32'hDEADBEEF; mem_lat = 2;
        memread_mem = 1; alu_result_mem = 32'h100;
        for (int k = 0; k < 5; k++) begin
            req_bits[k] = ext_req;
            commit();
            rdy_bits[k] = last_rdy;
        end
        memread_mem = 0;
        commit(); commit();
        chk("load_req_cycles", {27'd0, req_bits}, 32'h0000000E);
        chk("load_ready_cycles", {27'd0, rdy_bits}, 32'h00000010);
        chk("load_data", data_from_memory_mem, 32'hDEADBEEF);

        // Store
        force_rd = 32'h99999999; mem_lat = 1;
        memwrite_mem = 1; alu_result_mem = 32'h40; write_data_memory_mem = 32'h12345678;
        got = 0; cap_we = 0; cap_addr = '0; cap_wdata = '0;
        for (int k = 0; k < 12 && !got; k++) begin
            if (ext_req) begin cap_we = ext_we; cap_addr = ext_addr; cap_wdata = ext_wdata; end
            commit();
            if (last_rdy) got = 1;
        end
        memwrite_mem = 0;
        commit(); commit();
        chk1("store_done", got, 1'b1);
        chk1("store_we", cap_we, 1'b1);
        chk("store_addr", cap_addr, 32'h40);
        chk("store_wdata", cap_wdata, 32'h12345678);
        chk("store_keeps_dout", data_from_memory_mem, 32'hDEADBEEF);

        // Contention: data and fetch requested every cycle
        grants.delete();
        force_rd_en = 0;
        memread_mem = 1; alu_result_mem = 32'h1000; fetch_req = 1; fetch_addr = 32'h2000;
        prev_dreq = ext_req;
        for (int cyc = 0; cyc < 300 && (grants.size() < 10 || dgr.size() < 10); cyc++) begin
            if (ext_req && !prev_dreq) dgr.push_back(ext_addr >= 32'h2000);
            prev_dreq = ext_req;
            if (prev_rdy) alu_result_mem = alu_result_mem + 4;
            if (m_fv) fetch_addr = fetch_addr + 4;
            commit();
        end
        mg = '0; dg = '0;
        for (int i = 0; i < 10; i++) begin
            if (i < grants.size()) mg[i] = grants[i];
            if (i < dgr.size()) dg[i] = dgr[i];
        end
        chk("model_grant_order", {22'd0, mg}, 32'h00000210);
        chk("dut_grant_order", {22'd0, dg}, 32'h00000210);
        for (int cyc = 0; cyc < 50 && (memread_mem || fetch_req || m_busy); cyc++) begin
            if (prev_rdy) memread_mem = 0;
            if (m_fv) fetch_req = 0;
            commit();
        end
        idle_inputs();
        commit(); commit();

        // Flush during FETCH, ack two cycles after the flush
        force_rd_en = 1; force_rd = 32'hCAFEF00D; mem_lat = 3;
        fetch_req = 1; fetch_addr = 32'h80;
        for (int k = 0; k < 10 && !ext_req; k++) commit();
        commit();
        if_flush = 1;
        commit();
        if_flush = 0; fetch_addr = 32'h200;
        fv_cnt = 0; saw200 = 0;
        for (int k = 0; k < 30; k++) begin
            if (ext_req && ext_addr == 32'h200) saw200 = 1;
            if (m_fv) fetch_req = 0;
            commit();
            if (last_fv) fv_cnt++;
        end
        chk("flush_fv_count", fv_cnt, 32'd1);
        chk1("flush_new_addr", saw200, 1'b1);
        chk("flush_new_rdata", fetch_rdata, 32'hCAFEF00D);

        // Reset one cycle after ext_req rises on a load
        idle_inputs();
        mem_lat = 4; memread_mem = 1; alu_result_mem = 32'h300;
        for (int k = 0; k < 10 && !ext_req; k++) commit();
        commit();
        rstn = 0;
        #1;
        chk1("midrst_ext_req", ext_req, 1'b0);
        chk1("midrst_ext_we", ext_we, 1'b0);
        chk("midrst_ext_addr", ext_addr, 32'h0);
        chk1("midrst_fetch_valid", fetch_valid, 1'b0);
        chk("midrst_dout", data_from_memory_mem, 32'h0);
        chk1("midrst_data_ready", data_ready_mem, 1'b0);
        model_reset();
        mem_phase = 0;
        memread_mem = 0; ext_ack = 0;
        @(negedge clk);
        rstn = 1;
        force_rd = 32'h0BADF00D; mem_lat = 2;
        memread_mem = 1; alu_result_mem = 32'h304;
        got = 0;
        for (int k = 0; k < 15 && !got; k++) begin
            commit();
            if (last_rdy) got = 1;
        end
        memread_mem = 0;
        commit();
        chk1("postrst_load_done", got, 1'b1);
        chk("postrst_load_data", data_from_memory_mem, 32'h0BADF00D);

        // Spurious ack in IDLE
        idle_inputs();
        force_rd = 32'hFFFFFFFF;
        force_ack = 1;
        commit();
        force_ack = 0;
        chk1("spurious_ext_req", ext_req, 1'b0);
        chk1("spurious_fv", fetch_valid, 1'b0);
        chk("spurious_dout", data_from_memory_mem, 32'h0BADF00D);
        memread_mem = 1; alu_result_mem = 32'h500; force_rd = 32'h55AA55AA;
        commit();
        chk1("spurious_no_done", last_rdy, 1'b0);
        for (int k = 0; k < 15 && !prev_rdy; k++) commit();
        memread_mem = 0;
        commit();

        // Random traffic against the model
        force_rd_en = 0; rand_lat = 1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (prev_rdy) begin
                r = $urandom_range(0, 3);
                memread_mem = (r == 1);
                memwrite_mem = (r == 2);
                alu_result_mem = $urandom & 32'hFFFF_FFFC;
                write_data_memory_mem = $urandom;
            end
            if_flush = ($urandom_range(0, 11) == 0);
            if (if_flush) begin
                fetch_req = 1;
                fetch_addr = $urandom & 32'hFFFF_FFFC;
            end else if (m_fv) begin
                fetch_req = ($urandom_range(0, 3) != 0);
                fetch_addr = fetch_addr + 4;
            end else if (!fetch_req) begin
                fetch_req = ($urandom_range(0, 3) == 0);
            end
            commit();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
